// File: rtl/i2c_slave_regif_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the I2C register-interface target: protocol FSM
// state encoding and the default device address.
package i2c_slave_regif_pkg;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1010011;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG_ADDR  = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

endpackage

// File: rtl/i2c_slave_regif_line_filter.sv
`timescale 1ns/1ps
// Input conditioner for both I2C lines: synchroniser, glitch filter, and
// single-cycle edge / START / STOP pulses derived from the filtered levels.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_LEN  = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  localparam int CW = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN) : 1;

  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] r_levelDly;
  logic       w_sclRise;
  logic       w_sclFall;
  logic       w_sdaRise;
  logic       w_sdaFall;

  assign w_raw = {i_scl, i_sda};

  // Bit 1 is SCL, bit 0 is SDA. Lines idle high, so everything resets to 1
  // to avoid a spurious edge when reset is released on an idle bus.
  for (genvar g = 0; g < 2; g++) begin : g_line
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_sync  <= '1;
        r_cnt   <= '0;
        r_level <= 1'b1;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        if (r_sync[SYNC_STAGES-1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(GLITCH_LEN - 1)) begin
          r_level <= r_sync[SYNC_STAGES-1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_level[g] = r_level;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_levelDly <= 2'b11;
    end else begin
      r_levelDly <= w_level;
    end
  end

  assign w_sclRise = w_level[1] & ~r_levelDly[1];
  assign w_sclFall = ~w_level[1] & r_levelDly[1];
  assign w_sdaRise = w_level[0] & ~r_levelDly[0];
  assign w_sdaFall = ~w_level[0] & r_levelDly[0];

  assign o_sda      = w_level[0];
  assign o_scl_rise = w_sclRise;
  assign o_scl_fall = w_sclFall;
  assign o_start    = w_sdaFall & w_level[1];
  assign o_stop     = w_sdaRise & w_level[1];

endmodule

// File: rtl/i2c_slave_regif.sv
`timescale 1ns/1ps
// I2C target with an 8-bit register port: one register-address byte, then
// data bytes with auto-incrementing address, for both writes and reads.
module i2c_slave_regif
  import i2c_slave_regif_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         GLITCH_LEN  = 3
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  input  logic       i_i2c_scl,
  inout  wire        io_i2c_sda,
  output logic [7:0] o_reg_addr,
  output logic       o_reg_wr_en,
  output logic [7:0] o_reg_wr_data,
  output logic       o_reg_rd_en,
  input  logic [7:0] i_reg_rd_data,
  output logic       o_busy,
  output logic       o_addr_hit
);

  logic w_sdaIn;
  logic w_sclRise;
  logic w_sclFall;
  logic w_start;
  logic w_stop;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .GLITCH_LEN (GLITCH_LEN)
  ) u_filter (
    .i_clk     (i_sys_clk),
    .i_rst_n   (i_sys_rst_n),
    .i_scl     (i_i2c_scl),
    .i_sda     (io_i2c_sda),
    .o_sda     (w_sdaIn),
    .o_scl_rise(w_sclRise),
    .o_scl_fall(w_sclFall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  state_t     r_state,   w_state;
  logic [2:0] r_bitCnt,  w_bitCnt;
  logic [7:0] r_shift,   w_shift;
  logic       r_sdaLow,  w_sdaLow;
  logic       r_ackPhase, w_ackPhase;
  logic       r_rw,      w_rw;
  logic [7:0] r_regAddr, w_regAddr;
  logic       r_busy,    w_busy;
  logic [7:0] r_wrData,  w_wrData;
  logic       r_addrHit, w_addrHit;
  logic       r_wrEn,    w_wrEn;
  logic       r_rdEn,    w_rdEn;
  logic       r_rdLoad;
  logic [7:0] w_byte;
  logic       w_lastBit;

  assign w_byte    = {r_shift[6:0], w_sdaIn};
  assign w_lastBit = (r_bitCnt == 3'd7);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_bitCnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_sdaLow   <= 1'b0;
      r_ackPhase <= 1'b0;
      r_rw       <= 1'b0;
      r_regAddr  <= 8'h00;
      r_busy     <= 1'b0;
      r_wrData   <= 8'h00;
      r_addrHit  <= 1'b0;
      r_wrEn     <= 1'b0;
      r_rdEn     <= 1'b0;
      r_rdLoad   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_bitCnt   <= w_bitCnt;
      r_shift    <= w_shift;
      r_sdaLow   <= w_sdaLow;
      r_ackPhase <= w_ackPhase;
      r_rw       <= w_rw;
      r_regAddr  <= w_regAddr;
      r_busy     <= w_busy;
      r_wrData   <= w_wrData;
      r_addrHit  <= w_addrHit;
      r_wrEn     <= w_wrEn;
      r_rdEn     <= w_rdEn;
      r_rdLoad   <= r_rdEn;
    end
  end

  // r_ackPhase is the 9th-bit flag: in ACK states it marks that the ACK is
  // being driven; in RD_ACK it marks that the master acknowledged.
  always_comb begin
    w_state    = r_state;
    w_bitCnt   = r_bitCnt;
    w_shift    = r_shift;
    w_sdaLow   = r_sdaLow;
    w_ackPhase = r_ackPhase;
    w_rw       = r_rw;
    w_regAddr  = r_regAddr;
    w_busy     = r_busy;
    w_wrData   = r_wrData;
    w_addrHit  = 1'b0;
    w_wrEn     = 1'b0;
    w_rdEn     = 1'b0;

    if (r_rdLoad) w_shift = i_reg_rd_data;
    if (r_wrEn)   w_regAddr = r_regAddr + 8'd1;

    if (w_stop) begin
      w_state    = ST_IDLE;
      w_sdaLow   = 1'b0;
      w_busy     = 1'b0;
      w_ackPhase = 1'b0;
    end else if (w_start) begin
      w_state    = ST_ADDR;
      w_bitCnt   = 3'd0;
      w_sdaLow   = 1'b0;
      w_ackPhase = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (w_sclRise) begin
            w_shift  = w_byte;
            w_bitCnt = r_bitCnt + 3'd1;
            if (w_lastBit) begin
              w_ackPhase = 1'b0;
              if (r_state == ST_ADDR) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  w_addrHit = 1'b1;
                  w_busy    = 1'b1;
                  w_rw      = w_byte[0];
                  w_state   = ST_ADDR_ACK;
                end else begin
                  w_busy  = 1'b0;
                  w_state = ST_WAIT_STOP;
                end
              end else if (r_state == ST_REG_ADDR) begin
                w_regAddr = w_byte;
                w_state   = ST_REG_ACK;
              end else begin
                w_wrEn   = 1'b1;
                w_wrData = w_byte;
                w_state  = ST_WR_ACK;
              end
            end
          end
        end

        ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: begin
          if (w_sclFall) begin
            if (!r_ackPhase) begin
              w_sdaLow   = 1'b1;
              w_ackPhase = 1'b1;
            end else begin
              w_ackPhase = 1'b0;
              w_bitCnt   = 3'd0;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                w_sdaLow = ~r_shift[7];
                w_state  = ST_RD_DATA;
              end else begin
                w_sdaLow = 1'b0;
                w_state  = (r_state == ST_ADDR_ACK) ? ST_REG_ADDR : ST_WR_DATA;
              end
            end
          end else if (w_sclRise && r_ackPhase && r_state == ST_ADDR_ACK && r_rw) begin
            w_rdEn = 1'b1;
          end
        end

        ST_RD_DATA: begin
          if (w_sclFall) begin
            if (w_lastBit) begin
              w_sdaLow   = 1'b0;
              w_ackPhase = 1'b0;
              w_state    = ST_RD_ACK;
            end else begin
              w_sdaLow = ~r_shift[6];
              w_shift  = {r_shift[6:0], 1'b0};
              w_bitCnt = r_bitCnt + 3'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (w_sclRise && !r_ackPhase) begin
            if (!w_sdaIn) begin
              w_ackPhase = 1'b1;
              w_regAddr  = r_regAddr + 8'd1;
              w_rdEn     = 1'b1;
            end else begin
              w_busy  = 1'b0;
              w_state = ST_WAIT_STOP;
            end
          end else if (w_sclFall && r_ackPhase) begin
            w_ackPhase = 1'b0;
            w_bitCnt   = 3'd0;
            w_sdaLow   = ~r_shift[7];
            w_state    = ST_RD_DATA;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign io_i2c_sda    = r_sdaLow ? 1'b0 : 1'bz;
  assign o_reg_addr    = r_regAddr;
  assign o_reg_wr_en   = r_wrEn;
  assign o_reg_wr_data = r_wrData;
  assign o_reg_rd_en   = r_rdEn;
  assign o_busy        = r_busy;
  assign o_addr_hit    = r_addrHit;

endmodule

// File: tb/tb_i2c_slave_regif.sv
`timescale 1ns/1ps
// Directed bench for the I2C register target: a bit-banged master, a
// registered register-file model, and table-driven write transactions.
module tb_i2c_slave_regif;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] regA;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       expAck;
    logic [7:0] expA0;
    logic [7:0] expA1;
    int         tq;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic tbSdaLow = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = tbSdaLow ? 1'b0 : 1'bz;

  logic [7:0] regAddr;
  logic [7:0] wrData;
  logic [7:0] rdModel = 8'h00;
  logic       wrEn;
  logic       rdEn;
  logic       busy;
  logic       addrHit;

  int checks = 0;
  int errors = 0;
  int tQ = 620;
  int hitCount = 0;
  logic [15:0] wrLog[$];
  logic [7:0]  rdLog[$];

  i2c_slave_regif #(
    .SLAVE_ADDR (7'b1010011),
    .SYNC_STAGES(2),
    .GLITCH_LEN (3)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_i2c_scl    (scl),
    .io_i2c_sda   (sda),
    .o_reg_addr   (regAddr),
    .o_reg_wr_en  (wrEn),
    .o_reg_wr_data(wrData),
    .o_reg_rd_en  (rdEn),
    .i_reg_rd_data(rdModel),
    .o_busy       (busy),
    .o_addr_hit   (addrHit)
  );

  always #10 clk = ~clk;

  // Register file model: contents are address + 0x80, one-cycle read latency.
  always @(posedge clk) begin
    if (rdEn) rdModel <= regAddr + 8'h80;
    if (rdEn) rdLog.push_back(regAddr);
    if (wrEn) wrLog.push_back({regAddr, wrData});
    if (addrHit) hitCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic i2cStart();
    tbSdaLow = 1'b0;
    #(tQ);
    scl = 1'b1;
    #(tQ);
    tbSdaLow = 1'b1;
    #(tQ);
    scl = 1'b0;
    #(tQ);
  endtask

  task automatic i2cStop();
    tbSdaLow = 1'b1;
    #(tQ);
    scl = 1'b1;
    #(tQ);
    tbSdaLow = 1'b0;
    #(tQ);
  endtask

  task automatic writeBit(input logic b);
    tbSdaLow = ~b;
    #(tQ);
    scl = 1'b1;
    #(2 * tQ);
    scl = 1'b0;
    #(tQ);
  endtask

  task automatic readBit(output logic b);
    tbSdaLow = 1'b0;
    #(tQ);
    scl = 1'b1;
    #(tQ);
    b = sda;
    #(tQ);
    scl = 1'b0;
    #(tQ);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ackBit);
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(ackBit);
  endtask

  task automatic readByte(output logic [7:0] d, input logic masterNack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      d[i] = b;
    end
    writeBit(masterNack);
  endtask

  // One full write transaction: device address, register address, two data bytes.
  task automatic applyStimulus(input vec_t v, input string tag);
    logic a;
    int wrBase;
    int hitBase;
    logic [7:0] expAckBit;
    wrBase  = wrLog.size();
    hitBase = hitCount;
    tQ = v.tq;
    expAckBit = v.expAck ? 8'd0 : 8'd1;
    i2cStart();
    writeByte(v.dev, a);
    checkOutput({tag, " ack dev"}, 32'(a), 32'(expAckBit[0]));
    checkOutput({tag, " busy mid"}, 32'(busy), 32'(v.expAck));
    writeByte(v.regA, a);
    checkOutput({tag, " ack reg"}, 32'(a), 32'(expAckBit[0]));
    writeByte(v.d0, a);
    checkOutput({tag, " ack d0"}, 32'(a), 32'(expAckBit[0]));
    writeByte(v.d1, a);
    checkOutput({tag, " ack d1"}, 32'(a), 32'(expAckBit[0]));
    i2cStop();
    #(4 * tQ);
    checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
    checkOutput({tag, " sda released"}, 32'(sda), 32'd1);
    checkOutput({tag, " addr_hit count"}, 32'(hitCount - hitBase), v.expAck ? 32'd1 : 32'd0);
    checkOutput({tag, " write count"}, 32'(wrLog.size() - wrBase), v.expAck ? 32'd2 : 32'd0);
    if (v.expAck && wrLog.size() >= wrBase + 2) begin
      checkOutput({tag, " write0"}, 32'(wrLog[wrBase]), 32'({v.expA0, v.d0}));
      checkOutput({tag, " write1"}, 32'(wrLog[wrBase + 1]), 32'({v.expA1, v.d1}));
    end
  endtask

  vec_t vecs[4];

  initial begin
    logic a;
    logic b;
    logic [7:0] d;
    int rdBase;
    int wrBase;
    int hitBase;
    logic [7:0] expRd[3];
    vec_t vPost;

    vecs[0] = '{8'hA6, 8'h5A, 8'h11, 8'h22, 1'b1, 8'h5A, 8'h5B, 2500};
    vecs[1] = '{8'h90, 8'h5A, 8'h33, 8'h44, 1'b0, 8'h00, 8'h00, 620};
    vecs[2] = '{8'hA6, 8'hFF, 8'hAA, 8'hBB, 1'b1, 8'hFF, 8'h00, 620};
    vecs[3] = '{8'hA6, 8'h00, 8'h5C, 8'hA3, 1'b1, 8'h00, 8'h01, 620};

    @(negedge clk);
    checkOutput("reset reg_addr", 32'(regAddr), 32'd0);
    checkOutput("reset wr_en", 32'(wrEn), 32'd0);
    checkOutput("reset rd_en", 32'(rdEn), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset addr_hit", 32'(addrHit), 32'd0);
    checkOutput("reset sda", 32'(sda), 32'd1);
    #200;
    rst_n = 1'b1;
    #400;

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Random read: set register 0x10, repeated START, read three bytes.
    $display("[TB] random read");
    tQ = 620;
    rdBase  = rdLog.size();
    hitBase = hitCount;
    expRd[0] = 8'h90;
    expRd[1] = 8'h91;
    expRd[2] = 8'h92;
    i2cStart();
    writeByte(8'hA6, a);
    checkOutput("rr ack dev wr", 32'(a), 32'd0);
    writeByte(8'h10, a);
    checkOutput("rr ack reg", 32'(a), 32'd0);
    i2cStart();
    writeByte(8'hA7, a);
    checkOutput("rr ack dev rd", 32'(a), 32'd0);
    checkOutput("rr busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      readByte(d, (k == 2));
      checkOutput($sformatf("rr byte%0d", k), 32'(d), 32'(expRd[k]));
    end
    checkOutput("rr sda after nack", 32'(sda), 32'd1);
    checkOutput("rr busy after nack", 32'(busy), 32'd0);
    i2cStop();
    #(4 * tQ);
    checkOutput("rr rd_en count", 32'(rdLog.size() - rdBase), 32'd3);
    if (rdLog.size() >= rdBase + 3) begin
      checkOutput("rr rd addr0", 32'(rdLog[rdBase]), 32'h10);
      checkOutput("rr rd addr1", 32'(rdLog[rdBase + 1]), 32'h11);
      checkOutput("rr rd addr2", 32'(rdLog[rdBase + 2]), 32'h12);
    end
    checkOutput("rr addr_hit count", 32'(hitCount - hitBase), 32'd2);
    checkOutput("rr final reg_addr", 32'(regAddr), 32'h12);

    // STOP after four bits of a data byte must discard the partial byte.
    $display("[TB] stop mid-byte");
    wrBase = wrLog.size();
    i2cStart();
    writeByte(8'hA6, a);
    writeByte(8'h40, a);
    writeBit(1'b1);
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b0);
    i2cStop();
    #(4 * tQ);
    checkOutput("mid stop write count", 32'(wrLog.size() - wrBase), 32'd0);
    checkOutput("mid stop busy", 32'(busy), 32'd0);
    checkOutput("mid stop sda", 32'(sda), 32'd1);
    vPost = '{8'hA6, 8'h41, 8'h7E, 8'h81, 1'b1, 8'h41, 8'h42, 620};
    applyStimulus(vPost, "after stop");

    // Reset while the target drives a 0 data bit (bit 6 of 0x90).
    $display("[TB] reset during read");
    i2cStart();
    writeByte(8'hA6, a);
    writeByte(8'h10, a);
    i2cStart();
    writeByte(8'hA7, a);
    readBit(b);
    checkOutput("rst first bit", 32'(b), 32'd1);
    checkOutput("rst target drives 0", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #100;
    checkOutput("rst sda released", 32'(sda), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst reg_addr", 32'(regAddr), 32'd0);
    #100;
    rst_n = 1'b1;
    #200;
    scl = 1'b1;
    #1000;
    vPost = '{8'hA6, 8'h33, 8'h44, 8'h55, 1'b1, 8'h33, 8'h34, 620};
    applyStimulus(vPost, "post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
I2C target (responder) that answers an I2C master at a fixed 7-bit address. It exposes a simple 8-bit register read/write port on the system clock. Used as an on-board test partner for the I2C master, and as a register-access path for external masters. Byte protocol is one 8-bit register-address byte followed by data bytes, with the address auto-incrementing per byte.

Parameters:
SLAVE_ADDR, 7'b1010011, 7-bit device address this target ACKs.
SYNC_STAGES, 2, synchroniser flops on SCL/SDA inputs (2..3 allowed).
GLITCH_LEN, 3, sys_clk cycles a synchronised level must be stable before it is accepted (glitch filter).

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst_n  in  1  asynchronous active-low reset.
i2c_scl  in  1  bus clock from the master (no clock stretching).
i2c_sda  inout  1  open-drain data; driven 1'b0 or 1'bz only.
reg_addr  out  8  register address for the current access.
reg_wr_en  out  1  one-cycle write strobe.
reg_wr_data  out  8  write data, valid when reg_wr_en=1.
reg_rd_en  out  1  one-cycle read request.
reg_rd_data  in  8  read data, sampled exactly 1 cycle after reg_rd_en.
busy  out  1  high from an addressed START until STOP/NACK-exit.
addr_hit  out  1  one-cycle pulse when the device address matches.

Behaviour:
- Reset: all outputs 0, SDA released (z), state IDLE, reg_addr=8'h00, shift register 0. Reset mid-transfer releases SDA immediately.
- Input path: SCL and SDA pass through SYNC_STAGES flops, then the GLITCH_LEN filter. Edges are detected on the filtered levels, one pulse each: scl_rise, scl_fall, sda_rise, sda_fall.
- START = sda_fall while SCL high. STOP = sda_rise while SCL high. Both are recognised in every state.
  - START (including repeated START) goes to ADDR with bit counter 0.
  - STOP goes to IDLE, releases SDA, and clears busy.
- Data bits are sampled on scl_rise, MSB first. SDA is changed only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th scl_rise, compare [7:1] with SLAVE_ADDR.
    - Match: pulse addr_hit, set busy, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP; SDA stays released, so the master sees a NACK.
  - ADDR_ACK: drive SDA low from the scl_fall after the 8th bit to the next scl_fall.
    - R/W=0: go to REG_ADDR.
    - R/W=1: pulse reg_rd_en at the scl_rise of the ACK bit. Load the shift register from reg_rd_data on the next cycle. On the scl_fall ending the ACK, drive the MSB and go to RD_DATA.
  - REG_ADDR: shift 8 bits. After the 8th scl_rise, set reg_addr to that byte. ACK in REG_ACK, then go to WR_DATA.
  - WR_DATA: shift 8 bits. At the 8th scl_rise, reg_wr_en=1 for exactly one cycle, with reg_wr_data = byte and reg_addr = current address. Then WR_ACK (ACK driven). reg_addr increments on the cycle after the strobe, 8'hFF wraps to 8'h00. Loop back to WR_DATA.
  - RD_DATA: on each scl_fall, drive the next bit (bit=0 drives low, bit=1 releases SDA). After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit at scl_rise.
    - ACK (0): increment reg_addr (wrapping), pulse reg_rd_en on the same cycle, and reload on the next cycle. On scl_fall, drive the MSB and go to RD_DATA.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bits until STOP or START.
- A read issued immediately after a write phase (repeated START, R/W=1) uses the reg_addr last set or incremented. This gives the standard EEPROM random read.
- A STOP or START arriving mid-byte in WR_DATA discards the partial byte: no reg_wr_en.
- SDA is never driven while SCL is high, except for holding an ACK or data bit across the high phase.
- Bit counter is 3-bit plus a 9th-bit flag; the shift register is 8-bit. No arithmetic beyond the 8-bit address increment.

Decomposition:
- Shared package holds the state encoding localparams (IDLE, ADDR, ADDR_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP) and the default SLAVE_ADDR.
- One sub-module, i2c_line_filter: synchroniser, glitch filter and edge/START/STOP detector, instantiated once covering both lines.
- The protocol FSM and the register port live in the top module.

Test Plan:
- Master at 100 kHz writes addr 0xA6, reg 0x5A, data 0x11, 0x22, then STOP -> ACK on all 4 bytes; reg_wr_en pulses twice: (0x5A,0x11) then (0x5B,0x22); busy low after STOP.
- Random read: write addr 0xA6, reg 0x10, repeated START, addr 0xA7, read 3 bytes (ACK, ACK, NACK), with reg model data = addr+0x80 -> bytes on SDA are 0x90, 0x91, 0x92; reg_rd_en pulses 3 times; SDA released after NACK.
- Address 0x90 (mismatch) followed by 2 data bytes -> no ACK, no reg_wr_en/reg_rd_en/addr_hit, busy stays 0.
- Write reg 0xFF with data 0xAA, 0xBB -> writes to 0xFF then 0x00 (wrap).
- STOP injected after 4 bits of a data byte -> no reg_wr_en, state IDLE, SDA z.
- sys_rst_n asserted while the target drives a 0 data bit -> SDA z within the reset, busy=0; after release, the next transaction at 400 kHz completes normally.
